// File: rtl/slack_sched.sv
// ----------------------------------------------------------------------------
// slack_sched : sequences the ADMM slack-projection unit over every horizon step
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slack_sched #(
  parameter int HORIZON = 10,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 15,
  parameter int AW      = (HORIZON > 1) ? $clog2(HORIZON) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          slk_start,
  input  logic          slk_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] step
);

  // One counter serves both the read-latency wait and the WAIT timeout.
  localparam int            C_CMAX      = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
  localparam int            C_CW        = $clog2(C_CMAX + 1);
  localparam logic [C_CW-1:0] C_LAT_END = C_CW'(RD_LAT - 1);
  localparam logic [C_CW-1:0] C_TMO_END = C_CW'(TIMEOUT - 1);
  localparam logic [AW-1:0] C_LAST_STEP = AW'(HORIZON - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LAT   = 3'd2,
    S_FIRE  = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   step_q, step_d;
  logic            err_q, err_d;

  logic busy_q, done_q, rd_en_q, slk_start_q, wr_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      slk_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      rd_en_q     <= (state_d == S_READ);
      slk_start_q <= (state_d == S_FIRE);
      wr_en_q     <= (state_d == S_WRITE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          step_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_READ: begin
        state_d = S_LAT;
        cnt_d   = '0;
      end
      S_LAT: begin
        if (cnt_q == C_LAT_END) begin
          state_d = S_FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (slk_done) begin
          state_d = S_WRITE;
        end else if (cnt_q == C_TMO_END) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (step_q == C_LAST_STEP) begin
          state_d = S_FIN;
        end else begin
          state_d = S_READ;
          step_d  = step_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats everything, including a simultaneous slk_done or timeout.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      step_d  = step_q;
      err_d   = err_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign slk_start = slk_start_q;
  assign wr_en     = wr_en_q;
  assign rd_addr   = step_q;
  assign wr_addr   = step_q;
  assign step      = step_q;

endmodule

`default_nettype wire

// File: tb/tb_slack_sched.sv
// ----------------------------------------------------------------------------
// tb_slack_sched : directed self-checking bench for slack_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_slack_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, slk_done;
  logic       busy, done, err, rd_en, slk_start, wr_en;
  logic [3:0] rd_addr, wr_addr, step;

  logic       start1, abort1, slk_done1;
  logic       busy1, done1, err1, rd_en1, slk_start1, wr_en1;
  logic [0:0] rd_addr1, wr_addr1, step1;

  slack_sched #(.HORIZON(10), .RD_LAT(1), .TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .slk_start(slk_start), .slk_done(slk_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .step(step)
  );

  slack_sched #(.HORIZON(1), .RD_LAT(3), .TIMEOUT(15)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .err(err1),
    .rd_en(rd_en1), .rd_addr(rd_addr1),
    .slk_start(slk_start1), .slk_done(slk_done1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .step(step1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slack model: answers dly[step] WAIT cycles after slk_start (0 = never).
  int dly [10];
  int rem = 0;
  bit abort_at5 = 1'b0;
  initial begin
    slk_done = 1'b0;
    abort    = 1'b0;
  end
  always @(negedge clk) begin
    slk_done = 1'b0;
    abort    = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        slk_done = 1'b1;
        if (abort_at5 && step == 4'd5) abort = 1'b1;
      end
    end
    if (slk_start) rem = dly[int'(step)];
  end

  bit s1_dly = 1'b0;
  initial slk_done1 = 1'b0;
  always @(negedge clk) begin
    slk_done1 = s1_dly;
    s1_dly    = slk_start1;
  end

  int wr_log [32];
  int rd_log [32];
  int wr_n, rd_n, done_n, done_cyc, fall_cyc;
  bit busy_prev = 1'b0;
  int wr1_n, done1_n, done1_cyc, rd1_cyc, fs1_cyc, wr1_addr;

  always @(negedge clk) begin
    if (wr_en && wr_n < 32) begin wr_log[wr_n] = int'(wr_addr); wr_n++; end
    if (rd_en && rd_n < 32) begin rd_log[rd_n] = int'(rd_addr); rd_n++; end
    if (done) begin done_n++; done_cyc = cyc; end
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
    if (rd_en1) rd1_cyc = cyc;
    if (slk_start1) fs1_cyc = cyc;
    if (wr_en1) begin wr1_n++; wr1_addr = int'(wr_addr1); end
    if (done1) begin done1_n++; done1_cyc = cyc; end
  end

  int st_cyc;

  task automatic clr();
    wr_n = 0; rd_n = 0; done_n = 0; done_cyc = -1; fall_cyc = -1;
    for (int i = 0; i < 10; i++) dly[i] = 1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start  = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start  = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("sweep_bound", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  int cnt3;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    clr();
    wr1_n = 0; done1_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_slk_start", slk_start, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addrs", {rd_addr, wr_addr, step}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Baseline sweep; latency is counted inclusively from start cycle to done cycle.
    clr();
    pulse_start();
    wait_idle(200);
    chk("base_wr_count", wr_n, 10);
    chk("base_rd_count", rd_n, 10);
    for (int i = 0; i < 10; i++) begin
      chk("base_rd_addr", rd_log[i], i);
      chk("base_wr_addr", wr_log[i], i);
    end
    chk("base_done_count", done_n, 1);
    chk("base_latency", done_cyc - st_cyc + 1, 52);
    chk("base_busy_fall", fall_cyc - done_cyc, 1);
    chk("base_err", err, 0);

    // Step 3 answers on its 4th WAIT cycle.
    clr();
    dly[3] = 4;
    pulse_start();
    wait_idle(200);
    cnt3 = 0;
    for (int i = 0; i < wr_n; i++) if (wr_log[i] == 3) cnt3++;
    chk("slow_wr_count", wr_n, 10);
    chk("slow_addr3_once", cnt3, 1);
    chk("slow_latency", done_cyc - st_cyc + 1, 55);

    // Step 2 never answers: timeout after 15 WAIT cycles.
    clr();
    dly[2] = 0;
    pulse_start();
    wait_idle(200);
    chk("tmo_err", err, 1);
    chk("tmo_done_count", done_n, 0);
    chk("tmo_wr_count", wr_n, 2);
    chk("tmo_busy_fall", fall_cyc - st_cyc, 29);
    clr();
    pulse_start();
    chk("tmo_err_cleared", err, 0);
    wait_idle(200);
    chk("tmo_rerun_wr_count", wr_n, 10);
    chk("tmo_rerun_done", done_n, 1);
    chk("tmo_rerun_err", err, 0);

    // Abort coinciding with slk_done at step 5; a start while busy is ignored.
    clr();
    abort_at5 = 1'b1;
    pulse_start();
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200);
    abort_at5 = 1'b0;
    chk("abort_wr_count", wr_n, 5);
    chk("abort_rd_count", rd_n, 6);
    chk("abort_done_count", done_n, 0);
    chk("abort_err", err, 0);
    chk("abort_busy_fall", fall_cyc - st_cyc, 30);

    // Asynchronous reset during LAT of step 7.
    clr();
    pulse_start();
    for (int n = 0; n < 200; n++) begin
      if (rd_en && rd_addr == 4'd7) break;
      @(negedge clk);
    end
    chk("rst7_reached", {rd_en, rd_addr}, {1'b1, 4'd7});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst7_busy", busy, 0);
    chk("rst7_strobes", {rd_en, slk_start, wr_en, done, err}, 0);
    chk("rst7_addrs", {rd_addr, wr_addr, step}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst7_wr_count", wr_n, 7);
    clr();
    pulse_start();
    wait_idle(200);
    chk("rst7_rerun_first_wr", wr_log[0], 0);
    chk("rst7_rerun_wr_count", wr_n, 10);
    chk("rst7_rerun_latency", done_cyc - st_cyc + 1, 52);

    // HORIZON=1, RD_LAT=3 instance.
    @(negedge clk);
    start1 = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done1_n != 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("h1_done_count", done1_n, 1);
    chk("h1_lat_gap", fs1_cyc - rd1_cyc, 4);
    chk("h1_wr_count", wr1_n, 1);
    chk("h1_wr_addr", wr1_addr, 0);
    chk("h1_latency", done1_cyc - st_cyc + 1, 9);
    chk("h1_idle", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
